// File: rtl/temp_sample_seq.sv
// Sampling sequencer: periodic 4-phase req/ack sensor read, BCD validation,
// |new - prev| magnitude in BCD, and late got_value publication.
module temp_sample_seq #(
   parameter int unsigned SAMPLE_PERIOD = 1000,
   parameter int unsigned ACK_TIMEOUT   = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       sens_req,
   input  logic       sens_ack,
   input  logic [3:0] sens_ones,
   input  logic [3:0] sens_tens,
   input  logic [3:0] sens_huns,
   input  logic       sens_sign,
   output logic [3:0] temp_ones_value,
   output logic [3:0] temp_tens_value,
   output logic [3:0] temp_huns_value,
   output logic [3:0] out_ones,
   output logic [3:0] out_tens,
   output logic [3:0] out_huns,
   output logic [2:0] diff_read,
   output logic       got_value,
   output logic       sign_mode_changed,
   output logic       timeout_err,
   output logic       bcd_err,
   output logic       busy
);

   localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
   localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [PW-1:0] PERIOD_LOAD = PW'(SAMPLE_PERIOD - 1);
   localparam logic [TW-1:0] PHASE_LAST  = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_REQ, S_RELEASE, S_CALC, S_PUB
   } state_t;

   state_t r_state, w_next;

   logic [PW-1:0] r_period;
   logic [TW-1:0] r_phase;
   logic          w_timeout, w_load_period, w_bad;

   logic [3:0] r_new_ones, r_new_tens, r_new_huns;
   logic       r_new_sign;
   logic [3:0] r_prev_ones, r_prev_tens, r_prev_huns;
   logic       r_prev_sign;
   logic       r_sign_flag;

   logic [9:0]  w_new_bin, w_prev_bin, w_diff_bin;
   logic [11:0] w_diff_bcd;

   function automatic logic [9:0] bcd2bin(input logic [3:0] h, input logic [3:0] t,
                                           input logic [3:0] o);
      return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
   endfunction

   // Shift-and-add-3; inputs never exceed 999 so the top digit cannot overflow.
   function automatic logic [11:0] bin2bcd(input logic [9:0] b);
      logic [11:0] d;
      d = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (d[3:0]  > 4'd4) d[3:0]  = d[3:0]  + 4'd3;
         if (d[7:4]  > 4'd4) d[7:4]  = d[7:4]  + 4'd3;
         if (d[11:8] > 4'd4) d[11:8] = d[11:8] + 4'd3;
         d = {d[10:0], b[9 - i]};
      end
      return d;
   endfunction

   assign w_bad      = (r_new_ones > 4'd9) || (r_new_tens > 4'd9) || (r_new_huns > 4'd9);
   assign w_new_bin  = bcd2bin(r_new_huns, r_new_tens, r_new_ones);
   assign w_prev_bin = bcd2bin(r_prev_huns, r_prev_tens, r_prev_ones);
   assign w_diff_bin = (w_new_bin >= w_prev_bin) ? (w_new_bin - w_prev_bin)
                                                 : (w_prev_bin - w_new_bin);
   assign w_diff_bcd = bin2bcd(w_diff_bin);

   always_comb begin
      w_next        = r_state;
      w_timeout     = 1'b0;
      w_load_period = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_next        = S_WAIT;
               w_load_period = 1'b1;
            end
         end
         S_WAIT: begin
            if (!enable)              w_next = S_IDLE;
            else if (r_period == '0)  w_next = S_REQ;
         end
         S_REQ: begin
            if (sens_ack) begin
               w_next = S_RELEASE;
            end else if (r_phase == PHASE_LAST) begin
               w_next        = S_WAIT;
               w_timeout     = 1'b1;
               w_load_period = 1'b1;
            end
         end
         S_RELEASE: begin
            if (!sens_ack) begin
               w_next = S_CALC;
            end else if (r_phase == PHASE_LAST) begin
               w_next        = S_WAIT;
               w_timeout     = 1'b1;
               w_load_period = 1'b1;
            end
         end
         S_CALC: begin
            if (w_bad) begin
               w_next        = S_WAIT;
               w_load_period = 1'b1;
            end else begin
               w_next = S_PUB;
            end
         end
         S_PUB: begin
            w_next        = S_WAIT;
            w_load_period = 1'b1;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_period    <= '0;
         r_phase     <= '0;
         sens_req    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         bcd_err     <= 1'b0;
         got_value   <= 1'b0;
         sign_mode_changed <= 1'b0;
      end else begin
         r_state <= w_next;

         if (w_load_period)                          r_period <= PERIOD_LOAD;
         else if (r_state == S_IDLE)                 r_period <= '0;
         else if (r_state == S_WAIT && r_period != '0) r_period <= r_period - 1'b1;

         // Phase counter restarts on every entry into REQ or RELEASE.
         if (w_next != r_state)                                   r_phase <= '0;
         else if (r_state == S_REQ || r_state == S_RELEASE)      r_phase <= r_phase + 1'b1;
         else                                                     r_phase <= '0;

         sens_req          <= (w_next == S_REQ);
         busy              <= (w_next != S_IDLE);
         timeout_err       <= w_timeout;
         bcd_err           <= (r_state == S_CALC) && w_bad;
         got_value         <= (r_state == S_PUB);
         sign_mode_changed <= (r_state == S_PUB) && r_sign_flag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_new_ones      <= '0;
         r_new_tens      <= '0;
         r_new_huns      <= '0;
         r_new_sign      <= 1'b0;
         r_prev_ones     <= '0;
         r_prev_tens     <= '0;
         r_prev_huns     <= '0;
         r_prev_sign     <= 1'b0;
         r_sign_flag     <= 1'b0;
         temp_ones_value <= '0;
         temp_tens_value <= '0;
         temp_huns_value <= '0;
         out_ones        <= '0;
         out_tens        <= '0;
         out_huns        <= '0;
         diff_read       <= '0;
      end else begin
         if (r_state == S_REQ && sens_ack) begin
            r_new_ones <= sens_ones;
            r_new_tens <= sens_tens;
            r_new_huns <= sens_huns;
            r_new_sign <= sens_sign;
         end

         if (r_state == S_CALC && !w_bad) begin
            temp_ones_value <= r_new_ones;
            temp_tens_value <= r_new_tens;
            temp_huns_value <= r_new_huns;
            if (diff_read != '0) begin
               {out_huns, out_tens, out_ones} <= w_diff_bcd;
            end else begin
               {out_huns, out_tens, out_ones} <= '0;
            end
            r_sign_flag <= (diff_read != '0) && (r_new_sign != r_prev_sign);
            r_prev_ones <= r_new_ones;
            r_prev_tens <= r_new_tens;
            r_prev_huns <= r_new_huns;
            r_prev_sign <= r_new_sign;
         end

         if (r_state == S_PUB && diff_read < 3'd2) diff_read <= diff_read + 3'd1;
      end
   end

endmodule

// File: tb/tb_temp_sample_seq.sv
// Directed bench for temp_sample_seq with a req/ack responder and an
// expected-result queue popped on each got_value pulse.
module tb_temp_sample_seq;

   localparam int unsigned P  = 8;
   localparam int unsigned AT = 4;

   logic       clk = 1'b0;
   logic       rst, enable, sens_ack, sens_sign;
   logic [3:0] sens_ones, sens_tens, sens_huns;
   logic       sens_req, got_value, sign_mode_changed, timeout_err, bcd_err, busy;
   logic [3:0] temp_ones_value, temp_tens_value, temp_huns_value;
   logic [3:0] out_ones, out_tens, out_huns;
   logic [2:0] diff_read;

   always #5 clk = ~clk;

   temp_sample_seq #(.SAMPLE_PERIOD(P), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .sens_req(sens_req), .sens_ack(sens_ack),
      .sens_ones(sens_ones), .sens_tens(sens_tens), .sens_huns(sens_huns),
      .sens_sign(sens_sign),
      .temp_ones_value(temp_ones_value), .temp_tens_value(temp_tens_value),
      .temp_huns_value(temp_huns_value),
      .out_ones(out_ones), .out_tens(out_tens), .out_huns(out_huns),
      .diff_read(diff_read), .got_value(got_value),
      .sign_mode_changed(sign_mode_changed), .timeout_err(timeout_err),
      .bcd_err(bcd_err), .busy(busy)
   );

   typedef struct {
      logic [11:0] temp;
      logic [11:0] out;
      logic        smc;
      logic [2:0]  dr;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;
   int rsp_mode = 0;   // 0 immediate ack, 1 never ack, 2 ack stuck high
   int n_to = 0, n_got = 0, n_bcd = 0;
   int m_prev = 0, m_cnt = 0;
   logic m_sign = 1'b0;
   logic [11:0] prev_temp_s = '0, cur_temp_s = '0;

   initial begin
      sens_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) sens_ack = 1'b0;
         else if (rsp_mode == 0) sens_ack = sens_req;
         else if (rsp_mode == 1) sens_ack = 1'b0;
         else if (sens_req) sens_ack = 1'b1;
      end
   end

   function automatic logic [11:0] to_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      prev_temp_s = cur_temp_s;
      @(negedge clk);
      cur_temp_s = {temp_huns_value, temp_tens_value, temp_ones_value};
      n_to  += int'(timeout_err);
      n_got += int'(got_value);
      n_bcd += int'(bcd_err);
   endtask

   task automatic push_sample(input int h, input int t, input int o, input logic s);
      exp_t e;
      int v, d;
      sens_huns = 4'(h); sens_tens = 4'(t); sens_ones = 4'(o); sens_sign = s;
      v = h * 100 + t * 10 + o;
      d = (v >= m_prev) ? v - m_prev : m_prev - v;
      e.temp = to_bcd(v);
      e.out  = (m_cnt >= 1) ? to_bcd(d) : 12'h000;
      e.smc  = (m_cnt >= 1) && (s != m_sign);
      m_prev = v;
      m_sign = s;
      m_cnt  = (m_cnt >= 2) ? 2 : m_cnt + 1;
      e.dr   = 3'(m_cnt);
      sb.push_back(e);
   endtask

   task automatic wait_got(input string tag);
      exp_t e;
      int   n = 0;
      do begin tick(); n++; end while (!got_value && n < 200);
      chk({tag, "_got_seen"}, 32'(got_value), 32'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      if (!got_value) return;
      chk({tag, "_temp"}, 32'(cur_temp_s), 32'(e.temp));
      chk({tag, "_out"}, 32'({out_huns, out_tens, out_ones}), 32'(e.out));
      chk({tag, "_diff_read"}, 32'(diff_read), 32'(e.dr));
      chk({tag, "_smc"}, 32'(sign_mode_changed), 32'(e.smc));
      chk({tag, "_setup"}, 32'(prev_temp_s), 32'(e.temp));
      tick();
      chk({tag, "_got_width"}, 32'(got_value), 32'd0);
   endtask

   task automatic wait_req_rise(input string tag);
      int n = 0;
      while (!sens_req && n < 100) begin tick(); n++; end
      chk({tag, "_req_rise"}, 32'(sens_req), 32'd1);
   endtask

   initial begin
      int cnt, got0;
      rst = 1'b1; enable = 1'b0;
      sens_ones = '0; sens_tens = '0; sens_huns = '0; sens_sign = 1'b0;
      repeat (3) tick();
      chk("rst_req", 32'(sens_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dr", 32'(diff_read), 32'd0);
      chk("rst_temp", 32'(cur_temp_s), 32'd0);
      chk("rst_pulses", 32'({got_value, sign_mode_changed, timeout_err, bcd_err}), 32'd0);
      rst = 1'b0;
      tick();

      push_sample(3, 9, 8, 1'b0);
      enable = 1'b1;
      wait_got("s398");
      push_sample(4, 0, 3, 1'b0);
      cnt = 1;
      while (!sens_req && cnt < 100) begin tick(); cnt++; end
      chk("interval", 32'(cnt), 32'(P));
      wait_got("s403");
      push_sample(4, 7, 0, 1'b0);
      wait_got("s470");
      push_sample(4, 1, 5, 1'b0);
      wait_got("s415");
      push_sample(2, 5, 0, 1'b0);
      wait_got("s250a");
      push_sample(2, 5, 0, 1'b1);
      wait_got("s250b");

      // No-ack timeout in REQ, then ack stuck high in RELEASE.
      rsp_mode = 1; n_to = 0; n_got = 0;
      wait_req_rise("noack");
      cnt = 0;
      while (sens_req && cnt < 50) begin cnt++; tick(); end
      chk("noack_req_cycles", 32'(cnt), 32'(AT));
      chk("noack_to_count", 32'(n_to), 32'd1);
      rsp_mode = 2;
      cnt = 0;
      while (!sens_req && cnt < 100) begin tick(); cnt++; end
      chk("noack_retry_gap", 32'(cnt), 32'(P));
      cnt = 0;
      while (n_to < 2 && cnt < 40) begin tick(); cnt++; end
      chk("stuck_to_count", 32'(n_to), 32'd2);
      rsp_mode = 0;
      repeat (2) tick();
      chk("to_no_got", 32'(n_got), 32'd0);
      chk("to_temp_kept", 32'(cur_temp_s), 32'h250);
      chk("to_pulse_once", 32'(n_to), 32'd2);

      // Invalid digit: discarded, prev stays at last good reading.
      sens_huns = 4'd3; sens_tens = 4'd0; sens_ones = 4'hA; sens_sign = 1'b1;
      n_bcd = 0; got0 = n_got;
      cnt = 0;
      while (!bcd_err && cnt < 100) begin tick(); cnt++; end
      chk("bcd_err_seen", 32'(bcd_err), 32'd1);
      tick();
      chk("bcd_err_once", 32'(n_bcd), 32'd1);
      chk("bcd_no_got", 32'(n_got), 32'(got0));
      chk("bcd_temp_kept", 32'(cur_temp_s), 32'h250);
      push_sample(2, 6, 0, 1'b1);
      wait_got("s260");

      // Asynchronous reset mid-REQ.
      rsp_mode = 1;
      wait_req_rise("rstreq");
      tick();
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(sens_req), 32'd0);
      chk("arst_dr", 32'(diff_read), 32'd0);
      chk("arst_temp", 32'({temp_huns_value, temp_tens_value, temp_ones_value}), 32'd0);
      chk("arst_out", 32'({out_huns, out_tens, out_ones}), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      repeat (2) tick();
      rsp_mode = 0;
      m_prev = 0; m_cnt = 0; m_sign = 1'b0;
      sb.delete();
      rst = 1'b0;
      push_sample(1, 2, 3, 1'b1);
      wait_got("cold123");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/temp_sample_seq.md
# temp_sample_seq

Sampling sequencer that drives the temperature datapath. It periodically requests a 3-digit BCD reading (00.0–99.9) plus sign from the sensor front end over a 4-phase req/ack handshake. Each accepted reading is validated and latched, and the controller computes the BCD magnitude of change versus the previous reading. It then presents the values to the temperature state classifier with a clean, late-asserted `got_value` pulse and a `sign_mode_changed` pulse.

## Interface
- SAMPLE_PERIOD, 1000: cycles spent in WAIT between samples (≥2).
- ACK_TIMEOUT, 255: max cycles allowed in each handshake phase (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run sampling while high.
- sens_req  out  1  sample request (4-phase).
- sens_ack  in  1  sample acknowledge; digits/sign valid while high.
- sens_ones, sens_tens, sens_huns  in  4 each  BCD reading (tenths, ones, tens of degrees).
- sens_sign  in  1  reading sign (1 = negative mode).
- temp_ones_value, temp_tens_value, temp_huns_value  out  4 each  latest accepted reading.
- out_ones, out_tens, out_huns  out  4 each  BCD |latest − previous|.
- diff_read  out  3  accepted-reading count, saturates at 2.
- got_value  out  1  one-cycle pulse: new reading published.
- sign_mode_changed  out  1  one-cycle pulse: sign differs from previous reading.
- timeout_err  out  1  one-cycle pulse: handshake phase exceeded ACK_TIMEOUT.
- bcd_err  out  1  one-cycle pulse: captured digit > 9, sample discarded.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, WAIT, REQ, RELEASE, CALC, PUB.
- IDLE: counters clear. On `enable`=1, go to WAIT with the period counter loaded to SAMPLE_PERIOD−1.
- WAIT: decrement each cycle. At 0, go to REQ. If `enable`=0, go to IDLE; all latched values and `diff_read` are retained.
- `enable` is examined only in IDLE/WAIT. A transaction started in REQ completes through PUB or an error.
- REQ: `sens_req`=1. On the first cycle `sens_ack`=1:
  - capture digits and sign into the new-sample register;
  - drop `sens_req` (registered, low the next cycle);
  - go to RELEASE.
- RELEASE: wait for `sens_ack`=0, then go to CALC.
- Timeout: a phase counter restarts on entry to REQ and to RELEASE. After ACK_TIMEOUT cycles without the awaited ack level:
  - pulse `timeout_err`;
  - force `sens_req`=0;
  - discard the sample and return to WAIT (full period).
- CALC, invalid sample: if any captured digit is >9, pulse `bcd_err`, discard the sample and return to WAIT.
- CALC, valid sample:
  - register `temp_*_value` ← new digits;
  - register `out_*` ← BCD |new − prev| when `diff_read`≥1, else 000;
  - register pending sign-change flag = (`diff_read`≥1) && (new sign ≠ prev sign);
  - set prev ← new;
  - go to PUB.
- PUB:
  - `got_value`=1 for exactly one cycle;
  - `sign_mode_changed`=1 in the same cycle if the flag is set;
  - `diff_read` ← min(`diff_read`+1, 2);
  - go to WAIT.
- Difference arithmetic:
  - operate on decimal value huns·100 + tens·10 + ones (0–999);
  - result is 0–999, re-encoded as 3 BCD digits;
  - sign is not included in the magnitude;
  - equal readings give 000.

## Timing
- Reset values: `sens_req`=0, all digit outputs 0, `diff_read`=0, all pulses 0, `busy`=0, state IDLE. Reset takes effect immediately, including mid-handshake.
- The ack-capture edge is cycle N:
  - `temp_*`/`out_*` update at the N+2 edge (RELEASE exit at N+1 when ack is already low);
  - `got_value` rises one cycle after the data update, so data is stable ≥1 cycle before its rising edge;
  - data is held until the next PUB.
- All outputs are registered; no combinational path from inputs to outputs.
- Sample interval (PUB to next REQ) is exactly SAMPLE_PERIOD+1 cycles.

## Test plan
- Reset, then `enable`=1 with an immediate-ack responder returning 0x398 → first `got_value` pulse; `temp`=398, `out`=000, `diff_read`=1, no `sign_mode_changed`.
- Second reading 0x403 → `out`=005, `diff_read`=2. Third reading 0x470 then 0x415 → `out`=055. `diff_read` stays at 2.
- Sign flips 0→1 between two reads of 0x250 → `sign_mode_changed` and `got_value` pulse in the same cycle; `out`=000.
- Responder never acks (ACK_TIMEOUT=4) → `sens_req` drops after 4 cycles, `timeout_err` pulses once, outputs unchanged, next REQ after a full period. Repeat with ack stuck high in RELEASE → same result.
- Digit 0xA captured → `bcd_err` pulses, no `got_value`, prev unchanged (next diff is against the last good reading).
- `rst` asserted while in REQ → `sens_req`, `diff_read` and all outputs are 0 asynchronously. After release, behaviour matches a cold start.
